exmem_io: RTL and testbench

Dual-port word memory with a parametrised memory-mapped I/O window on port A. Port A serves the CPU: RAM plus N output registers, N synchronised input ports and a sticky change-event register. Port B is a RAM-only port for the display/DMA side. Successor to the single-LED/single-switch memory block. I/O reads are now registered, inputs are synchronised, and the I/O window is relocatable.

---
 rtl/exmem_io_pkg.sv | 31 +++
 rtl/exmem_io_sync_edge.sv | 37 +++
 rtl/exmem_io.sv | 121 ++++++++++++
 tb/tb_exmem_io.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/exmem_io_pkg.sv
// Shared constants and decode helpers for the exmem_io memory/I-O block.
package exmem_io_pkg;

   localparam int unsigned MAX_CHANNELS = 8;

   typedef enum logic [1:0] {
      IO_NONE,
      IO_OUT,
      IO_IN,
      IO_EVT
   } io_kind_e;

   function automatic int unsigned off_out0();
      return 0;
   endfunction

   function automatic int unsigned off_in0(input int unsigned num_out);
      return num_out;
   endfunction

   function automatic int unsigned off_event(input int unsigned num_out, input int unsigned num_in);
      return num_out + num_in;
   endfunction

   // Subtraction is only evaluated once addr >= base, so it cannot wrap.
   function automatic logic io_hit(input logic [31:0] addr, input logic [31:0] base,
                                   input logic [31:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage

// File: rtl/exmem_io_sync_edge.sv
// Per-channel two-flop synchroniser followed by a prev register for change detection.
module io_sync_edge #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out,
   output logic             chg
);

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] prev_q, prev_d;

   always_comb begin
      sync1_d = d_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   assign q_out = sync2_q;
   assign chg   = (sync2_q != prev_q);

endmodule

// File: rtl/exmem_io.sv
// Dual-port word RAM; port A additionally decodes a relocatable I/O window
// (output registers, synchronised inputs, sticky change-event register).
module exmem_io
   import exmem_io_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH = 16,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 16'h007F,
   parameter int unsigned           NUM_OUT    = 2,
   parameter int unsigned           NUM_IN     = 2,
   parameter int unsigned           IO_WIDTH   = 8,
   parameter string                 INIT_FILE  = "program.dat"
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_WIDTH-1:0]        addr1,
   input  logic [DATA_WIDTH-1:0]        dataIn1,
   input  logic                         we1,
   output logic [DATA_WIDTH-1:0]        dataOut1,
   input  logic [ADDR_WIDTH-1:0]        addr2,
   input  logic [DATA_WIDTH-1:0]        dataIn2,
   input  logic                         we2,
   output logic [DATA_WIDTH-1:0]        dataOut2,
   input  logic [NUM_IN*IO_WIDTH-1:0]   io_in,
   output logic [NUM_OUT*IO_WIDTH-1:0]  io_out
);

   localparam int unsigned OFF_OUT = off_out0();
   localparam int unsigned OFF_IN  = off_in0(NUM_OUT);
   localparam int unsigned OFF_EVT = off_event(NUM_OUT, NUM_IN);
   localparam int unsigned SPAN    = NUM_OUT + NUM_IN + 1;

   logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   logic [NUM_IN-1:0][IO_WIDTH-1:0]  in_sync;
   logic [NUM_IN-1:0]                chg;
   logic [NUM_OUT-1:0][IO_WIDTH-1:0] out_q, out_d;
   logic [NUM_IN-1:0]                evt_q, evt_d;
   logic [DATA_WIDTH-1:0]            dout1_q, dout1_d;
   logic [DATA_WIDTH-1:0]            dout2_q, dout2_d;
   logic                             hit;
   logic                             ram_we1;
   logic                             evt_clr;
   int unsigned                      off;
   io_kind_e                         kind;

   for (genvar g = 0; g < NUM_IN; g++) begin : g_in
      io_sync_edge #(
         .WIDTH (IO_WIDTH)
      ) u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d_in  (io_in[g*IO_WIDTH +: IO_WIDTH]),
         .q_out (in_sync[g]),
         .chg   (chg[g])
      );
   end

   // Port B is written first so that port A wins a same-word collision.
   always_ff @(posedge clk) begin
      if (we2) mem[addr2] <= dataIn2;
      if (ram_we1) mem[addr1] <= dataIn1;
   end

   always_comb begin
      hit     = io_hit(32'(addr1), 32'(IO_BASE), 32'(SPAN));
      off     = 32'(addr1 - IO_BASE);
      kind    = IO_NONE;
      out_d   = out_q;
      evt_clr = 1'b0;
      dout1_d = '0;
      ram_we1 = we1 && !hit;
      if (hit) begin
         for (int unsigned i = 0; i < NUM_OUT; i++) begin
            if (off == OFF_OUT + i) begin
               kind    = IO_OUT;
               dout1_d = DATA_WIDTH'(out_q[i]);
               if (we1) begin
                  out_d[i] = dataIn1[IO_WIDTH-1:0];
                  dout1_d  = DATA_WIDTH'(dataIn1[IO_WIDTH-1:0]);
               end
            end
         end
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (off == OFF_IN + i) begin
               kind    = IO_IN;
               dout1_d = DATA_WIDTH'(in_sync[i]);
            end
         end
         if (off == OFF_EVT) begin
            kind    = IO_EVT;
            dout1_d = DATA_WIDTH'(evt_q);
            evt_clr = !we1;
         end
      end else begin
         dout1_d = we1 ? dataIn1 : mem[addr1];
      end
      // A new change on the clearing edge survives the clear.
      evt_d   = (evt_q & ~{NUM_IN{evt_clr}}) | chg;
      dout2_d = we2 ? dataIn2 : mem[addr2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_q <= '0;
         dout2_q <= '0;
         out_q   <= '0;
         evt_q   <= '0;
      end else begin
         dout1_q <= dout1_d;
         dout2_q <= dout2_d;
         out_q   <= out_d;
         evt_q   <= evt_d;
      end
   end

   assign dataOut1 = dout1_q;
   assign dataOut2 = dout2_q;
   assign io_out   = out_q;

endmodule

// File: tb/tb_exmem_io.sv
// Scoreboard bench for exmem_io: stimulus queues expected outputs per edge,
// a negedge monitor pops and compares them.
module tb_exmem_io;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr1, dataIn1, dataOut1;
   logic [15:0] addr2, dataIn2, dataOut2;
   logic        we1, we2;
   logic [15:0] io_in;
   logic [15:0] io_out;

   int n_cmp = 0;
   int n_bad = 0;
   int edge_cnt = 0;

   typedef struct {
      int          at_edge;
      int          port;
      logic [15:0] exp;
      string       name;
   } exp_t;

   exp_t sb_q[$];

   exmem_io #(
      .INIT_FILE ("")
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .addr1    (addr1),
      .dataIn1  (dataIn1),
      .we1      (we1),
      .dataOut1 (dataOut1),
      .addr2    (addr2),
      .dataIn2  (dataIn2),
      .we2      (we2),
      .dataOut2 (dataOut2),
      .io_in    (io_in),
      .io_out   (io_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic expect_v(input int port, input logic [15:0] v, input string nm);
      exp_t e;
      e.at_edge = edge_cnt + 1;
      e.port    = port;
      e.exp     = v;
      e.name    = nm;
      sb_q.push_back(e);
   endtask

   task automatic set_a(input logic [15:0] a, input logic [15:0] d, input logic w);
      addr1 = a; dataIn1 = d; we1 = w;
   endtask

   task automatic set_b(input logic [15:0] a, input logic [15:0] d, input logic w);
      addr2 = a; dataIn2 = d; we2 = w;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Monitor: compares every queued expectation due at the latest edge.
   initial begin
      exp_t e;
      logic [15:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() != 0 && sb_q[0].at_edge <= edge_cnt) begin
            e = sb_q.pop_front();
            case (e.port)
               0:       act = dataOut1;
               1:       act = dataOut2;
               default: act = io_out;
            endcase
            check(e.name, act, e.exp);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      io_in = 16'hA55A;
      set_a(16'h0, 16'h0, 1'b0);
      set_b(16'h0, 16'h0, 1'b0);
      repeat (3) cyc();
      check("rst_dout1", dataOut1, 16'h0000);
      check("rst_dout2", dataOut2, 16'h0000);
      check("rst_io_out", io_out, 16'h0000);

      rst_n = 1'b1;
      io_in = 16'h0000;
      set_a(16'h0083, 16'h0, 1'b0);
      expect_v(0, 16'h0000, "evt_after_rst"); cyc();

      // RAM ports
      set_a(16'h0010, 16'h1234, 1'b1);
      expect_v(0, 16'h1234, "a_write_through"); cyc();
      set_a(16'h0000, 16'h0, 1'b0); set_b(16'h0010, 16'h0, 1'b0);
      expect_v(1, 16'h1234, "b_read_a_data"); cyc();
      set_a(16'h0020, 16'h1111, 1'b1); set_b(16'h0020, 16'h2222, 1'b1);
      expect_v(0, 16'h1111, "coll_wt_a");
      expect_v(1, 16'h2222, "coll_wt_b"); cyc();
      set_a(16'h0020, 16'h0, 1'b0); set_b(16'h0020, 16'h0, 1'b0);
      expect_v(0, 16'h1111, "coll_rd_a");
      expect_v(1, 16'h1111, "coll_rd_b"); cyc();
      set_a(16'h0010, 16'h0, 1'b0); set_b(16'h0010, 16'h9999, 1'b1);
      expect_v(0, 16'h1234, "rd_old_data"); cyc();
      set_b(16'h0000, 16'h0, 1'b0);
      expect_v(0, 16'h9999, "rd_new_data"); cyc();

      // Output registers
      set_a(16'h007F, 16'hBEEF, 1'b1);
      expect_v(0, 16'h00EF, "io_wt_trunc");
      expect_v(2, 16'h00EF, "io_out_wr"); cyc();
      set_a(16'h007F, 16'h0, 1'b0); set_b(16'h007F, 16'h5A5A, 1'b1);
      expect_v(0, 16'h00EF, "io_out_rd");
      expect_v(1, 16'h5A5A, "b_wt_in_window"); cyc();
      set_a(16'h0080, 16'h0, 1'b0); set_b(16'h007F, 16'h0, 1'b0);
      expect_v(0, 16'h0000, "out1_rst_val");
      expect_v(1, 16'h5A5A, "b_ram_in_window");
      expect_v(2, 16'h00EF, "io_out_b_immune"); cyc();
      set_a(16'h0000, 16'h0, 1'b0); set_b(16'h0081, 16'h1357, 1'b1); cyc();
      set_b(16'h0083, 16'h2468, 1'b1); cyc();
      set_b(16'h0000, 16'h0, 1'b0);

      // Input path: channel 1 becomes 3C
      io_in = 16'h3C00;
      set_a(16'h0082, 16'h0, 1'b0);
      expect_v(0, 16'h0000, "in_edge1"); cyc();
      expect_v(0, 16'h0000, "in_edge2"); cyc();
      expect_v(0, 16'h003C, "in_edge3"); cyc();
      set_a(16'h0083, 16'h0, 1'b0);
      expect_v(0, 16'h0002, "evt_set"); cyc();
      expect_v(0, 16'h0000, "evt_cleared"); cyc();

      // Channel 0 set lands on a clearing read
      io_in = 16'h3C01;
      expect_v(0, 16'h0000, "race_e1"); cyc();
      expect_v(0, 16'h0000, "race_e2"); cyc();
      expect_v(0, 16'h0000, "race_e3"); cyc();
      expect_v(0, 16'h0001, "race_set_wins"); cyc();
      expect_v(0, 16'h0000, "race_then_clr"); cyc();

      // Read-only protection
      set_a(16'h0081, 16'hFFFF, 1'b1); cyc();
      set_a(16'h0083, 16'hFFFF, 1'b1); cyc();
      set_a(16'h0081, 16'h0, 1'b0); set_b(16'h0081, 16'h0, 1'b0);
      expect_v(0, 16'h0001, "ro_in0");
      expect_v(1, 16'h1357, "ro_ram_81"); cyc();
      set_a(16'h0083, 16'h0, 1'b0); set_b(16'h0083, 16'h0, 1'b0);
      expect_v(0, 16'h0000, "ro_evt");
      expect_v(1, 16'h2468, "ro_ram_83");
      expect_v(2, 16'h00EF, "ro_io_out"); cyc();
      set_a(16'h0082, 16'h0, 1'b0); set_b(16'h0000, 16'h0, 1'b0);
      expect_v(0, 16'h003C, "ro_in1"); cyc();
      set_a(16'h0080, 16'h12AB, 1'b1);
      expect_v(0, 16'h00AB, "out1_wt");
      expect_v(2, 16'hABEF, "out1_io_out"); cyc();
      set_a(16'h0000, 16'h0, 1'b0);

      repeat (3) cyc();
      while (sb_q.size() != 0) begin
         exp_t e;
         e = sb_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no output, expected %h", e.name, e.exp);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
